// File: rtl/arb_dispatch_if.sv
// Bus bundle between arbiter/requesters/downstream and the burst dispatcher.
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high; once raised, out_valid stays high with stable
// out_src until that transfer happens. pop*/done*/err are single-cycle pulses.
interface arb_dispatch_if #(parameter int DW = 8);
  logic          gnt2, gnt1, gnt0;
  logic [DW-1:0] data2, data1, data0;
  logic          pop2, pop1, pop0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          done2, done1, done0;
  logic          busy;
  logic          err;
  logic [1:0]    dbg_state;

  // dispatcher side
  modport master (
    input  gnt2, gnt1, gnt0, data2, data1, data0, out_ready,
    output pop2, pop1, pop0, out_valid, out_data, out_src,
           done2, done1, done0, busy, err, dbg_state
  );

  // environment side (arbiter, requesters, downstream sink)
  modport slave (
    output gnt2, gnt1, gnt0, data2, data1, data0, out_ready,
    input  pop2, pop1, pop0, out_valid, out_data, out_src,
           done2, done1, done0, busy, err, dbg_state
  );
endinterface

// File: rtl/arb_dispatch.sv
// Burst dispatcher: latches the granted requester, streams BURST beats from
// its head word to the output port, pops it per accepted beat, then pulses
// done for that requester. Outputs are forced quiet while rst is high.
module arb_dispatch #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  arb_dispatch_if.master bus
);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [1:0]    src, src_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_q, err_nxt;

  logic [2:0]    gnt;
  logic          one_hot, multi_hot;
  logic          in_xfer, in_done, accept;
  logic [DW-1:0] mux_data;

  assign gnt       = {bus.gnt2, bus.gnt1, bus.gnt0};
  assign one_hot   = (gnt != 3'd0) && ((gnt & (gnt - 3'd1)) == 3'd0);
  assign multi_hot = ((gnt & (gnt - 3'd1)) != 3'd0);
  assign in_xfer   = (state == XFER) && !rst;
  assign in_done   = (state == DONE) && !rst;
  assign accept    = in_xfer && bus.out_ready;

  // State, source, beat counter and registered error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src   <= 2'd0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  // Next-state: grants only matter in IDLE; beats counted on acceptance
  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (one_hot) begin
          src_nxt   = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);
          cnt_nxt   = '0;
          state_nxt = XFER;
        end else if (multi_hot) begin
          err_nxt = 1'b1;
        end
      end
      XFER: begin
        if (accept) begin
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Live head-word mux for the latched source
  always_comb begin
    mux_data = bus.data0;
    case (src)
      2'd2:    mux_data = bus.data2;
      2'd1:    mux_data = bus.data1;
      default: mux_data = bus.data0;
    endcase
  end

  // Output decode from state; everything idles at zero outside a burst
  always_comb begin
    bus.out_valid = in_xfer;
    bus.out_data  = in_xfer ? mux_data : '0;
    bus.out_src   = (in_xfer || in_done) ? src : 2'd0;
    bus.pop0      = accept && (src == 2'd0);
    bus.pop1      = accept && (src == 2'd1);
    bus.pop2      = accept && (src == 2'd2);
    bus.done0     = in_done && (src == 2'd0);
    bus.done1     = in_done && (src == 2'd1);
    bus.done2     = in_done && (src == 2'd2);
    bus.busy      = in_xfer || in_done;
    bus.err       = err_q && !rst;
    bus.dbg_state = state;
  end
endmodule

// File: tb/tb_arb_dispatch.sv
// Bench for arb_dispatch: directed vector table on a BURST=4 instance,
// a hand sequence on a BURST=1 instance, then randomized traffic checked
// against a transaction-level model.
module tb_arb_dispatch;
  localparam int DW    = 8;
  localparam int BURST = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] tb_gnt, tb_gnt1;
  logic       tb_rdy;
  logic       head_init;
  logic [DW-1:0] head [3];

  arb_dispatch_if #(.DW(DW)) bus  ();
  arb_dispatch_if #(.DW(DW)) bus1 ();

  arb_dispatch #(.DW(DW), .BURST(BURST)) u_dut  (.clk(clk), .rst(rst), .bus(bus.master));
  arb_dispatch #(.DW(DW), .BURST(1))     u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  assign bus.gnt0  = tb_gnt[0];
  assign bus.gnt1  = tb_gnt[1];
  assign bus.gnt2  = tb_gnt[2];
  assign bus.out_ready = tb_rdy;
  assign bus.data0 = head[0];
  assign bus.data1 = head[1];
  assign bus.data2 = head[2];

  assign bus1.gnt0  = tb_gnt1[0];
  assign bus1.gnt1  = tb_gnt1[1];
  assign bus1.gnt2  = tb_gnt1[2];
  assign bus1.out_ready = 1'b1;
  assign bus1.data0 = 8'hA0;
  assign bus1.data1 = 8'hA1;
  assign bus1.data2 = 8'hA2;

  // requester FIFOs: head word advances on each pop
  always @(posedge clk) begin
    if (head_init) begin
      head[0] <= 8'h10;
      head[1] <= 8'h20;
      head[2] <= 8'h30;
    end else begin
      if (bus.pop0) head[0] <= head[0] + 8'd1;
      if (bus.pop1) head[1] <= head[1] + 8'd1;
      if (bus.pop2) head[2] <= head[2] + 8'd1;
    end
  end

  // observed output vector {valid, src, pop[2:0], done[2:0], busy, err, data}
  logic [18:0] o0, o1;
  assign o0 = {bus.out_valid, bus.out_src, bus.pop2, bus.pop1, bus.pop0,
               bus.done2, bus.done1, bus.done0, bus.busy, bus.err, bus.out_data};
  assign o1 = {bus1.out_valid, bus1.out_src, bus1.pop2, bus1.pop1, bus1.pop0,
               bus1.done2, bus1.done1, bus1.done0, bus1.busy, bus1.err, bus1.out_data};

  function automatic logic [18:0] mk(input logic v, input logic [1:0] s, input logic [2:0] p,
                                     input logic [2:0] d, input logic b, input logic e,
                                     input logic [7:0] dat);
    return {v, s, p, d, b, e, dat};
  endfunction

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got={v,src,pop,done,busy,err,data}=%h expected=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  gnt;
    logic        rdy;
    logic [18:0] exp;
  } row_t;
  row_t tbl[$];

  task automatic add(input logic r, input logic [2:0] g, input logic rd, input logic [18:0] e);
    row_t x;
    x.rst = r; x.gnt = g; x.rdy = rd; x.exp = e;
    tbl.push_back(x);
  endtask

  task automatic step1(input string name, input logic [2:0] g, input logic [18:0] e);
    @(posedge clk); #1;
    tb_gnt1 = g;
    @(negedge clk);
    check(name, o1, e);
  endtask

  // transaction-level reference model state
  int m_left, m_src;
  bit m_done, m_err;

  initial begin
    logic [18:0] z;
    logic [18:0] e;
    logic [2:0]  pe, de;
    logic        ix, dn;
    int          n, r;
    z = '0;
    rst = 1'b1; head_init = 1'b1; tb_gnt = 3'b000; tb_gnt1 = 3'b000; tb_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", o0, z);
    check("reset_outputs_b1", o1, z);
    n_cmp++;
    if (bus.dbg_state !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state got=%0d expected=0", bus.dbg_state);
    end

    // ---------- directed vector table (BURST=4) ----------
    // basic gnt1 burst
    add(0, 3'b000, 1, z);
    add(0, 3'b010, 1, z);
    for (int i = 0; i < 4; i++) add(0, 3'b000, 1, mk(1, 1, 3'b010, 0, 1, 0, 8'h20 + 8'(i)));
    add(0, 3'b000, 1, mk(0, 1, 0, 3'b010, 1, 0, 0));
    add(0, 3'b000, 1, z);
    // multi-hot grant in IDLE
    add(0, 3'b101, 1, z);
    add(0, 3'b000, 1, mk(0, 0, 0, 0, 0, 1, 0));
    add(0, 3'b000, 1, z);
    // gnt0 burst with stalls
    add(0, 3'b001, 0, z);
    add(0, 3'b000, 1, mk(1, 0, 3'b001, 0, 1, 0, 8'h10));
    add(0, 3'b001, 0, mk(1, 0, 0, 0, 1, 0, 8'h11));
    add(0, 3'b000, 0, mk(1, 0, 0, 0, 1, 0, 8'h11));
    add(0, 3'b000, 1, mk(1, 0, 3'b001, 0, 1, 0, 8'h11));
    add(0, 3'b000, 1, mk(1, 0, 3'b001, 0, 1, 0, 8'h12));
    add(0, 3'b000, 0, mk(1, 0, 0, 0, 1, 0, 8'h13));
    add(0, 3'b000, 1, mk(1, 0, 3'b001, 0, 1, 0, 8'h13));
    add(0, 3'b000, 1, mk(0, 0, 0, 3'b001, 1, 0, 0));
    add(0, 3'b000, 1, z);
    // grant changes ignored mid-burst, then back-to-back gnt1 burst
    add(0, 3'b100, 1, z);
    add(0, 3'b100, 1, mk(1, 2, 3'b100, 0, 1, 0, 8'h30));
    add(0, 3'b010, 1, mk(1, 2, 3'b100, 0, 1, 0, 8'h31));
    add(0, 3'b011, 1, mk(1, 2, 3'b100, 0, 1, 0, 8'h32));
    add(0, 3'b010, 1, mk(1, 2, 3'b100, 0, 1, 0, 8'h33));
    add(0, 3'b010, 1, mk(0, 2, 0, 3'b100, 1, 0, 0));
    add(0, 3'b010, 1, z);
    add(0, 3'b000, 1, mk(1, 1, 3'b010, 0, 1, 0, 8'h24));
    add(0, 3'b000, 1, mk(1, 1, 3'b010, 0, 1, 0, 8'h25));
    // reset mid-burst, then a full fresh burst
    add(1, 3'b000, 1, z);
    add(0, 3'b000, 1, z);
    add(0, 3'b010, 1, z);
    for (int i = 0; i < 4; i++) add(0, 3'b000, 1, mk(1, 1, 3'b010, 0, 1, 0, 8'h26 + 8'(i)));
    add(0, 3'b000, 1, mk(0, 1, 0, 3'b010, 1, 0, 0));
    add(0, 3'b000, 1, z);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      head_init = 1'b0;
      rst = tbl[i].rst; tb_gnt = tbl[i].gnt; tb_rdy = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d", i), o0, tbl[i].exp);
    end

    // ---------- BURST=1 back-to-back grants 0,1,2 ----------
    tb_gnt = 3'b000; tb_rdy = 1'b1;
    step1("b1_idle0", 3'b001, z);
    step1("b1_beat0", 3'b010, mk(1, 0, 3'b001, 0, 1, 0, 8'hA0));
    step1("b1_done0", 3'b010, mk(0, 0, 0, 3'b001, 1, 0, 0));
    step1("b1_idle1", 3'b010, z);
    step1("b1_beat1", 3'b100, mk(1, 1, 3'b010, 0, 1, 0, 8'hA1));
    step1("b1_done1", 3'b100, mk(0, 1, 0, 3'b010, 1, 0, 0));
    step1("b1_idle2", 3'b100, z);
    step1("b1_beat2", 3'b000, mk(1, 2, 3'b100, 0, 1, 0, 8'hA2));
    step1("b1_done2", 3'b000, mk(0, 2, 0, 3'b100, 1, 0, 0));
    step1("b1_idle3", 3'b000, z);

    // ---------- randomized traffic vs. model ----------
    @(posedge clk); #1;
    rst = 1'b1; tb_gnt = 3'b000;
    m_left = 0; m_src = 0; m_done = 0; m_err = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 49) == 0);
      r = $urandom_range(0, 9);
      if (r < 5)      tb_gnt = 3'b000;
      else if (r < 9) tb_gnt = 3'b001 << $urandom_range(0, 2);
      else            tb_gnt = 3'($urandom_range(0, 7));
      tb_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ix = (m_left > 0) && !rst;
      dn = m_done && !rst;
      pe = (ix && tb_rdy) ? (3'b001 << m_src) : 3'b000;
      de = dn ? (3'b001 << m_src) : 3'b000;
      e  = mk(ix, (ix || dn) ? 2'(m_src) : 2'd0, pe, de, ix || dn, m_err && !rst,
              ix ? head[m_src] : 8'h00);
      check($sformatf("rand%0d", c), o0, e);
      if (rst) begin
        m_left = 0; m_done = 0; m_err = 0; m_src = 0;
      end else if (m_left > 0) begin
        m_err = 0;
        if (tb_rdy) begin
          m_left--;
          if (m_left == 0) m_done = 1;
        end
      end else if (m_done) begin
        m_done = 0; m_err = 0;
      end else begin
        n = $countones(tb_gnt);
        m_err = (n >= 2);
        if (n == 1) begin
          m_src  = tb_gnt[2] ? 2 : (tb_gnt[1] ? 1 : 0);
          m_left = BURST;
        end
      end
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/arb_dispatch.md
ARB_DISPATCH -- requirements
Module: arb_dispatch

Interface
REQ-001 Parameter DW, default 8, data width of every requester and output data bus.
REQ-002 Parameter BURST, default 4, beats per granted transfer; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 gnt2, gnt1, gnt0  input  1 each  grant lines from the 3-way arbiter; expected one-hot or zero.
REQ-006 data2, data1, data0  input  DW each  current head word of each requester.
REQ-007 pop2, pop1, pop0  output  1 each  one-cycle pulse; the requester advances its head word on the next edge.
REQ-008 out_valid  output  1  output beat valid.
REQ-009 out_ready  input  1  downstream accepts the beat when high with out_valid.
REQ-010 out_data  output  DW  beat payload.
REQ-011 out_src  output  2  index 0..2 of the source requester for the current beat.
REQ-012 done2, done1, done0  output  1 each  one-cycle pulse at the end of that requester's burst.
REQ-013 busy  output  1  high while a burst is latched (XFER or DONE state).
REQ-014 err  output  1  one-cycle pulse on an illegal multi-hot grant.

Function
REQ-015 FSM states SHALL be IDLE, XFER and DONE, encoded as a registered state.
REQ-016 IDLE: exactly one gnt high -> latch index into src, beat counter cnt=0, next state XFER.
REQ-017 IDLE: two or more gnt high -> err=1 for the next cycle, remain IDLE, latch nothing.
REQ-018 IDLE: no gnt high -> remain IDLE, all outputs at reset values.
REQ-019 XFER: out_valid=1 combinationally from state; out_data=data[src] (live mux, not registered); out_src=src.
REQ-020 A beat is accepted when out_valid and out_ready are both high on a rising edge; pop[src] SHALL be high in exactly that cycle and no other pop SHALL be high.
REQ-021 On an accepted beat with cnt<BURST-1: cnt increments and the FSM remains in XFER.
REQ-022 On an accepted beat with cnt==BURST-1: next state DONE; cnt returns to 0.
REQ-023 out_ready low in XFER: hold state, cnt, out_data source and out_valid; out_valid SHALL NOT drop without acceptance.
REQ-024 Grant changes during XFER or DONE (drop, switch, multi-hot) SHALL be ignored; err SHALL NOT pulse outside IDLE.
REQ-025 DONE: done[src]=1 for exactly one cycle, out_valid=0, next state IDLE unconditionally.
REQ-026 A grant present in the first IDLE cycle after DONE SHALL start a new burst; minimum spacing is one IDLE cycle between bursts.
REQ-027 Latency: grant sampled at edge N -> out_valid high in cycle N+1; with out_ready held high, done pulse in cycle N+1+BURST.
REQ-028 cnt width SHALL be ceil(log2(BURST)) bits, minimum 1; no wrap beyond BURST-1.
REQ-029 busy SHALL be 1 in XFER and DONE, 0 in IDLE.

Reset
REQ-030 rst high at a rising edge SHALL force IDLE, src=0 and cnt=0, regardless of the current state, including mid-burst.
REQ-031 While rst is high and on the cycle after it is released: out_valid, pop*, done*, busy and err SHALL be 0; out_src=0; out_data=0.
REQ-032 An aborted burst SHALL NOT emit a done pulse; beats already accepted remain accepted.

Verification
REQ-033 BURST=4; gnt1=1 for one cycle; data1 increments on each pop1; out_ready=1 -> four beats with out_src=1 and consecutive data values; pop1 pulses 4 times; done1 pulses one cycle later; busy high for 5 cycles.
REQ-034 gnt0 burst; out_ready toggles 1,0,0,1,1,0,1 -> out_valid stays high and out_data stable while stalled; exactly 4 pops; done0 pulses after the 4th acceptance.
REQ-035 gnt0=gnt2=1 simultaneously in IDLE -> err pulses one cycle; no out_valid, no pop, busy stays 0.
REQ-036 During a gnt2 burst, gnt2 drops and gnt1 rises after beat 1 -> burst completes on src=2; done2 pulses; a gnt1 burst starts after one IDLE cycle.
REQ-037 rst asserted after beat 2 of a burst -> next cycle IDLE, all outputs 0, no done pulse; a new grant after rst release starts a burst at cnt=0.
REQ-038 BURST=1; back-to-back grants on 0, 1, 2 with out_ready=1 -> one beat each, with out_src 0, 1, 2 and done0, done1, done2 in order.
